// File: rtl/spu_resadd_top.sv
// Residual-add stage ahead of LayerNorm: reads A/B int8 word pairs from lbuf,
// writes sat8(rnd((A*sa + B*sb) >>> sh)) per lane back to lbuf.
module spu_resadd_top #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RLATENCY   = 1
) (
  input  logic                  core_clk,
  input  logic                  rst_n,
  input  logic                  ra_start,
  output logic                  ra_end,
  output logic                  ra_busy,
  input  logic [ADDR_WIDTH-1:0] spu_matrix_y,
  input  logic [ADDR_WIDTH-1:0] spu_matrix_x,
  input  logic [ADDR_WIDTH-1:0] ia_base_addr,
  input  logic [ADDR_WIDTH-1:0] ib_base_addr,
  input  logic [ADDR_WIDTH-1:0] om_base_addr,
  input  logic [ADDR_WIDTH-1:0] ifm_addr_align,
  input  logic [ADDR_WIDTH-1:0] ofm_addr_align,
  input  logic [6:0]            ra_scale_a,
  input  logic [6:0]            ra_scale_b,
  input  logic [3:0]            ra_shift,
  output logic                  ra_lbuf_ren,
  output logic [ADDR_WIDTH-1:0] ra_lbuf_raddr,
  input  logic [DATA_WIDTH-1:0] ra_lbuf_rdata,
  output logic                  ra_lbuf_wen,
  output logic [ADDR_WIDTH-1:0] ra_lbuf_waddr,
  output logic [DATA_WIDTH-1:0] ra_lbuf_wdata
);

  localparam int unsigned LANES = DATA_WIDTH / 8;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic                    ren_q, ren_d;
  logic [ADDR_WIDTH-1:0]   raddr_q, raddr_d;
  logic [ADDR_WIDTH-1:0]   rk_q, rk_d;
  logic [ADDR_WIDTH-1:0]   rr_q, rr_d;
  logic [ADDR_WIDTH-1:0]   rrow_q, rrow_d;
  logic                    rph_b_q, rph_b_d;
  logic [RLATENCY-1:0]     tag_vld_q, tag_vld_d;
  logic [RLATENCY-1:0]     tag_b_q, tag_b_d;
  logic [DATA_WIDTH-1:0]   a_hold_q, a_hold_d;
  logic                    wen_q, wen_d;
  logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    wlast_q, wlast_d;
  logic [ADDR_WIDTH-1:0]   wk_q, wk_d;
  logic [ADDR_WIDTH-1:0]   wr_q, wr_d;
  logic [ADDR_WIDTH-1:0]   wrow_q, wrow_d;
  logic                    end_q, end_d;
  logic                    busy_q, busy_d;

  logic [ADDR_WIDTH-1:0]   words_w;
  logic [ADDR_WIDTH-1:0]   col_last;
  logic [ADDR_WIDTH-1:0]   row_last;
  logic [RLATENCY:0]       tag_vld_ext;
  logic [RLATENCY:0]       tag_b_ext;
  logic [DATA_WIDTH-1:0]   lane_res;

  assign words_w  = spu_matrix_x >> 2;
  assign col_last = words_w - 1'b1;
  assign row_last = spu_matrix_y - 1'b1;

  function automatic logic [7:0] lane_calc(input logic [7:0] a, input logic [7:0] b,
                                           input logic [6:0] sa, input logic [6:0] sb,
                                           input logic [3:0] sh);
    logic signed [17:0] av, bv, sav, sbv, p;
    av  = 18'($signed(a));
    bv  = 18'($signed(b));
    sav = $signed({11'b0, sa});
    sbv = $signed({11'b0, sb});
    p   = av * sav + bv * sbv;
    if (sh != 4'd0) p = p + (18'sd1 <<< (sh - 4'd1));
    p = p >>> sh;
    if (p > 18'sd127)       lane_calc = 8'h7F;
    else if (p < -18'sd128) lane_calc = 8'h80;
    else                    lane_calc = p[7:0];
  endfunction

  always_comb begin
    lane_res = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      lane_res[8*i +: 8] = lane_calc(a_hold_q[8*i +: 8], ra_lbuf_rdata[8*i +: 8],
                                     ra_scale_a, ra_scale_b, ra_shift);
    end
  end

  // Tag pipeline: bit RLATENCY-1 lines up with the read data currently on ra_lbuf_rdata.
  assign tag_vld_ext = {tag_vld_q, ren_q};
  assign tag_b_ext   = {tag_b_q, rph_b_q};

  always_comb begin
    state_d   = state_q;
    ren_d     = 1'b0;
    raddr_d   = raddr_q;
    rk_d      = rk_q;
    rr_d      = rr_q;
    rrow_d    = rrow_q;
    rph_b_d   = rph_b_q;
    tag_vld_d = tag_vld_ext[RLATENCY-1:0];
    tag_b_d   = tag_b_ext[RLATENCY-1:0];
    a_hold_d  = a_hold_q;
    wen_d     = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    wlast_d   = wlast_q;
    wk_d      = wk_q;
    wr_d      = wr_q;
    wrow_d    = wrow_q;
    end_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ra_start) begin
          if (words_w == '0 || spu_matrix_y == '0) begin
            state_d = S_DONE;
            end_d   = 1'b1;
          end else begin
            state_d = S_RUN;
            ren_d   = 1'b1;
            raddr_d = ia_base_addr;
            rk_d    = '0;
            rr_d    = '0;
            rrow_d  = '0;
            rph_b_d = 1'b0;
            wk_d    = '0;
            wr_d    = '0;
            wrow_d  = '0;
          end
        end
      end
      S_RUN: begin
        if (!rph_b_q) begin
          ren_d   = 1'b1;
          rph_b_d = 1'b1;
          raddr_d = ib_base_addr + rrow_q + rk_q;
        end else if (rk_q == col_last && rr_q == row_last) begin
          state_d = S_DRAIN;
        end else begin
          ren_d   = 1'b1;
          rph_b_d = 1'b0;
          if (rk_q == col_last) begin
            rk_d   = '0;
            rr_d   = rr_q + 1'b1;
            rrow_d = rrow_q + ifm_addr_align;
          end else begin
            rk_d = rk_q + 1'b1;
          end
          raddr_d = ia_base_addr + rrow_d + rk_d;
        end
      end
      S_DRAIN: begin
        if (wen_q && wlast_q) begin
          state_d = S_DONE;
          end_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (tag_vld_q[RLATENCY-1]) begin
      if (!tag_b_q[RLATENCY-1]) begin
        a_hold_d = ra_lbuf_rdata;
      end else begin
        wen_d   = 1'b1;
        wdata_d = lane_res;
        waddr_d = om_base_addr + wrow_q + wk_q;
        wlast_d = (wk_q == col_last) && (wr_q == row_last);
        if (wk_q == col_last) begin
          wk_d   = '0;
          wr_d   = wr_q + 1'b1;
          wrow_d = wrow_q + ofm_addr_align;
        end else begin
          wk_d = wk_q + 1'b1;
        end
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ren_q     <= 1'b0;
      raddr_q   <= '0;
      rk_q      <= '0;
      rr_q      <= '0;
      rrow_q    <= '0;
      rph_b_q   <= 1'b0;
      tag_vld_q <= '0;
      tag_b_q   <= '0;
      a_hold_q  <= '0;
      wen_q     <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      wlast_q   <= 1'b0;
      wk_q      <= '0;
      wr_q      <= '0;
      wrow_q    <= '0;
      end_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ren_q     <= ren_d;
      raddr_q   <= raddr_d;
      rk_q      <= rk_d;
      rr_q      <= rr_d;
      rrow_q    <= rrow_d;
      rph_b_q   <= rph_b_d;
      tag_vld_q <= tag_vld_d;
      tag_b_q   <= tag_b_d;
      a_hold_q  <= a_hold_d;
      wen_q     <= wen_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      wlast_q   <= wlast_d;
      wk_q      <= wk_d;
      wr_q      <= wr_d;
      wrow_q    <= wrow_d;
      end_q     <= end_d;
      busy_q    <= busy_d;
    end
  end

  assign ra_end        = end_q;
  assign ra_busy       = busy_q;
  assign ra_lbuf_ren   = ren_q;
  assign ra_lbuf_raddr = raddr_q;
  assign ra_lbuf_wen   = wen_q;
  assign ra_lbuf_waddr = waddr_q;
  assign ra_lbuf_wdata = wdata_q;

endmodule

// File: tb/tb_spu_resadd_top.sv
// Directed bench for spu_resadd_top: lbuf model with RLAT-deep read pipe,
// read-address and write scoreboards filled from a reference lane model.
module tb_spu_resadd_top;

  localparam int AW   = 12;
  localparam int DW   = 32;
  localparam int RLAT = 2;

  logic          core_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ra_start = 1'b0;
  logic          ra_end, ra_busy;
  logic [AW-1:0] spu_matrix_y = '0, spu_matrix_x = '0;
  logic [AW-1:0] ia_base_addr = '0, ib_base_addr = '0, om_base_addr = '0;
  logic [AW-1:0] ifm_addr_align = '0, ofm_addr_align = '0;
  logic [6:0]    ra_scale_a = '0, ra_scale_b = '0;
  logic [3:0]    ra_shift = '0;
  logic          ra_lbuf_ren, ra_lbuf_wen;
  logic [AW-1:0] ra_lbuf_raddr, ra_lbuf_waddr;
  logic [DW-1:0] ra_lbuf_rdata, ra_lbuf_wdata;

  spu_resadd_top #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RLATENCY(RLAT)) u_dut (
    .core_clk(core_clk), .rst_n(rst_n), .ra_start(ra_start), .ra_end(ra_end), .ra_busy(ra_busy),
    .spu_matrix_y(spu_matrix_y), .spu_matrix_x(spu_matrix_x),
    .ia_base_addr(ia_base_addr), .ib_base_addr(ib_base_addr), .om_base_addr(om_base_addr),
    .ifm_addr_align(ifm_addr_align), .ofm_addr_align(ofm_addr_align),
    .ra_scale_a(ra_scale_a), .ra_scale_b(ra_scale_b), .ra_shift(ra_shift),
    .ra_lbuf_ren(ra_lbuf_ren), .ra_lbuf_raddr(ra_lbuf_raddr), .ra_lbuf_rdata(ra_lbuf_rdata),
    .ra_lbuf_wen(ra_lbuf_wen), .ra_lbuf_waddr(ra_lbuf_waddr), .ra_lbuf_wdata(ra_lbuf_wdata)
  );

  always #5 core_clk = ~core_clk;

  logic [DW-1:0] mem [0:4095];
  logic [DW-1:0] rpipe [0:RLAT-1];
  assign ra_lbuf_rdata = rpipe[RLAT-1];

  always @(posedge core_clk) begin
    rpipe[0] <= ra_lbuf_ren ? mem[ra_lbuf_raddr] : 32'hDEAD_BEEF;
    for (int i = 1; i < RLAT; i++) rpipe[i] <= rpipe[i-1];
    if (ra_lbuf_wen) mem[ra_lbuf_waddr] = ra_lbuf_wdata;
  end

  int checks = 0;
  int failures = 0;
  int ren_cnt = 0;
  int wen_cnt = 0;
  bit sb_en = 1'b1;
  logic [AW-1:0]    exp_ra [$];
  logic [AW+DW-1:0] exp_wr [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge core_clk) begin
    if (rst_n && sb_en) begin
      if (ra_lbuf_ren) begin
        ren_cnt++;
        if (exp_ra.size() == 0) chk("ren_unexpected", 64'(ra_lbuf_ren), 64'd0);
        else chk("raddr", 64'(ra_lbuf_raddr), 64'(exp_ra.pop_front()));
      end
      if (ra_lbuf_wen) begin
        wen_cnt++;
        if (exp_wr.size() == 0) chk("wen_unexpected", 64'(ra_lbuf_wen), 64'd0);
        else chk("waddr_wdata", 64'({ra_lbuf_waddr, ra_lbuf_wdata}), 64'(exp_wr.pop_front()));
      end
    end
  end

  function automatic logic [DW-1:0] ref_word(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input int sa, input int sb, input int sh);
    logic [DW-1:0] w;
    logic signed [7:0] ta, tb;
    int p;
    w = '0;
    for (int i = 0; i < DW/8; i++) begin
      ta = a[8*i +: 8];
      tb = b[8*i +: 8];
      p = int'(ta) * sa + int'(tb) * sb;
      if (sh > 0) p = p + (1 << (sh - 1));
      p = p >>> sh;
      if (p > 127) p = 127;
      if (p < -128) p = -128;
      w[8*i +: 8] = p[7:0];
    end
    return w;
  endfunction

  task automatic set_cfg(input int x, input int y, input int ia, input int ib, input int om,
                         input int ifa, input int ofa, input int sa, input int sb, input int sh);
    spu_matrix_x   = AW'(x);
    spu_matrix_y   = AW'(y);
    ia_base_addr   = AW'(ia);
    ib_base_addr   = AW'(ib);
    om_base_addr   = AW'(om);
    ifm_addr_align = AW'(ifa);
    ofm_addr_align = AW'(ofa);
    ra_scale_a     = 7'(sa);
    ra_scale_b     = 7'(sb);
    ra_shift       = 4'(sh);
  endtask

  // Expectations from the configuration and the pre-operation memory image.
  task automatic push_exp();
    int w;
    logic [AW-1:0] aa, ba, oa;
    w = int'(spu_matrix_x) >> 2;
    for (int r = 0; r < int'(spu_matrix_y); r++) begin
      for (int k = 0; k < w; k++) begin
        aa = AW'(int'(ia_base_addr) + r * int'(ifm_addr_align) + k);
        ba = AW'(int'(ib_base_addr) + r * int'(ifm_addr_align) + k);
        oa = AW'(int'(om_base_addr) + r * int'(ofm_addr_align) + k);
        exp_ra.push_back(aa);
        exp_ra.push_back(ba);
        exp_wr.push_back({oa, ref_word(mem[aa], mem[ba], int'(ra_scale_a), int'(ra_scale_b),
                                       int'(ra_shift))});
      end
    end
  endtask

  task automatic run_op(input string tag);
    bit got;
    int nw;
    nw = (int'(spu_matrix_x) >> 2) * int'(spu_matrix_y);
    push_exp();
    ren_cnt = 0;
    wen_cnt = 0;
    @(posedge core_clk); #1 ra_start = 1'b1;
    @(posedge core_clk); #1 ra_start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge core_clk);
      if (ra_end) got = 1'b1;
    end
    chk({tag, "_end_seen"}, 64'(got), 64'd1);
    @(negedge core_clk);
    chk({tag, "_busy_low"}, 64'(ra_busy), 64'd0);
    chk({tag, "_ren_count"}, 64'(ren_cnt), 64'(2 * nw));
    chk({tag, "_wen_count"}, 64'(wen_cnt), 64'(nw));
    chk({tag, "_sb_empty"}, 64'(exp_ra.size() + exp_wr.size()), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    for (int i = 0; i < RLAT; i++) rpipe[i] = '0;
    #23;
    chk("rst_ren",   64'(ra_lbuf_ren), 64'd0);
    chk("rst_wen",   64'(ra_lbuf_wen), 64'd0);
    chk("rst_end",   64'(ra_end), 64'd0);
    chk("rst_busy",  64'(ra_busy), 64'd0);
    chk("rst_raddr", 64'(ra_lbuf_raddr), 64'd0);
    chk("rst_waddr", 64'(ra_lbuf_waddr), 64'd0);
    chk("rst_wdata", 64'(ra_lbuf_wdata), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge core_clk);

    // Basic add
    mem[12'h100] = 32'h01020304; mem[12'h101] = 32'h05060708;
    mem[12'h200] = 32'h01010101; mem[12'h201] = 32'h01010101;
    set_cfg(8, 1, 'h100, 'h200, 'h300, 2, 2, 1, 1, 0);
    run_op("t1");
    chk("t1_word0", 64'(mem[12'h300]), 64'h02030405);
    chk("t1_word1", 64'(mem[12'h301]), 64'h06070809);

    // Saturation
    mem[12'h110] = 32'h7F7F7F7F; mem[12'h210] = 32'h7F7F7F7F;
    set_cfg(4, 1, 'h110, 'h210, 'h310, 1, 1, 1, 1, 0);
    run_op("t2a");
    chk("t2a_word", 64'(mem[12'h310]), 64'h7F7F7F7F);
    mem[12'h111] = 32'h80808080; mem[12'h211] = 32'h80808080;
    set_cfg(4, 1, 'h111, 'h211, 'h311, 1, 1, 1, 1, 0);
    run_op("t2b");
    chk("t2b_word", 64'(mem[12'h311]), 64'h80808080);
    mem[12'h112] = 32'h00000002; mem[12'h212] = 32'h12345678;
    set_cfg(4, 1, 'h112, 'h212, 'h312, 1, 1, 127, 0, 0);
    run_op("t2c");
    chk("t2c_word", 64'(mem[12'h312]), 64'h0000007F);

    // Round-half-up with shift
    mem[12'h113] = 32'hFF01FD03;
    set_cfg(4, 1, 'h113, 'h213, 'h313, 1, 1, 1, 0, 1);
    run_op("t3");
    chk("t3_word", 64'(mem[12'h313]), 64'h0001FF02);

    // Strided multi-row addressing
    set_cfg(16, 3, 'h10, 'h40, 'h80, 8, 6, 1, 1, 0);
    run_op("t4");

    // Random scales/shift and read-address wrap
    set_cfg(12, 2, 'h500, 'h600, 'h700, 5, 4, $urandom_range(0, 127), $urandom_range(0, 127),
            $urandom_range(0, 15));
    run_op("trand");
    set_cfg(16, 1, 'hFFE, 'h7FE, 'h3FE, 1, 1, 3, 5, 2);
    run_op("twrap");

    // Cycle-exact timing, start during DRAIN ignored
    set_cfg(4, 1, 'h120, 'h220, 'h320, 1, 1, 2, 1, 1);
    push_exp();
    ren_cnt = 0;
    wen_cnt = 0;
    @(posedge core_clk); #1 ra_start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge core_clk); #1 ra_start = (c == 3);
      @(negedge core_clk);
      chk($sformatf("t5_ren_c%0d", c),  64'(ra_lbuf_ren), 64'(c == 1 || c == 2));
      chk($sformatf("t5_wen_c%0d", c),  64'(ra_lbuf_wen), 64'(c == 5));
      chk($sformatf("t5_end_c%0d", c),  64'(ra_end),      64'(c == 6));
      chk($sformatf("t5_busy_c%0d", c), 64'(ra_busy),     64'(c >= 1 && c <= 6));
    end
    ra_start = 1'b0;
    chk("t5_ren_count", 64'(ren_cnt), 64'd2);
    chk("t5_wen_count", 64'(wen_cnt), 64'd1);

    // Degenerate sizes
    ren_cnt = 0;
    wen_cnt = 0;
    set_cfg(0, 4, 'h10, 'h40, 'h80, 1, 1, 1, 1, 0);
    @(posedge core_clk); #1 ra_start = 1'b1;
    @(negedge core_clk);
    chk("t6_end_c0", 64'(ra_end), 64'd0);
    @(posedge core_clk); #1 ra_start = 1'b0;
    @(negedge core_clk);
    chk("t6_end_c1", 64'(ra_end), 64'd1);
    @(negedge core_clk);
    chk("t6_end_c2", 64'(ra_end), 64'd0);
    chk("t6_busy_c2", 64'(ra_busy), 64'd0);
    set_cfg(8, 0, 'h10, 'h40, 'h80, 1, 1, 1, 1, 0);
    run_op("t6y0");
    chk("t6_no_traffic", 64'(ren_cnt + wen_cnt), 64'd0);

    // Reset mid-run
    sb_en = 1'b0;
    set_cfg(64, 4, 'h400, 'h600, 'h800, 16, 16, 1, 1, 0);
    @(posedge core_clk); #1 ra_start = 1'b1;
    @(posedge core_clk); #1 ra_start = 1'b0;
    repeat (10) @(posedge core_clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_ren",  64'(ra_lbuf_ren), 64'd0);
    chk("t6_rst_wen",  64'(ra_lbuf_wen), 64'd0);
    chk("t6_rst_busy", 64'(ra_busy), 64'd0);
    chk("t6_rst_end",  64'(ra_end), 64'd0);
    chk("t6_rst_raddr", 64'(ra_lbuf_raddr), 64'd0);
    repeat (2) @(posedge core_clk);
    #1 rst_n = 1'b1;
    exp_ra.delete();
    exp_wr.delete();
    sb_en = 1'b1;
    repeat (3) @(posedge core_clk);
    set_cfg(8, 2, 'h130, 'h230, 'h330, 4, 4, 9, 3, 3);
    run_op("t6_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
